fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage controller for the Y86 pipeline: owns the PC register that drives the instruction memory address and consumes the decoded fields it returns (icode, ifun, rA, rB, valC).
- Computes valP and predicts the next PC.
- Tracks fetch status (run / wait-for-ret / halt / error) and registers the fetched instruction into the F/D pipeline register feeding decode.

Parameters:
- DATA_WID, 32, width of PC, valC, valP and redirect address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- PC  out  DATA_WID  current fetch address to instruction memory.
- icode  in  4  instruction code from instruction memory.
- ifun  in  4  function code from instruction memory.
- rA  in  4  register A field.
- rB  in  4  register B field.
- valC  in  DATA_WID  constant word.
- stall  in  1  hold PC and F/D register.
- redirect_valid  in  1  downstream correction (mispredict or ret target).
- redirect_pc  in  DATA_WID  corrected fetch address.
- D_valid  out  1  F/D register holds a real instruction (0 = bubble).
- D_icode  out  4  registered icode.
- D_ifun  out  4  registered ifun.
- D_rA  out  4  registered rA.
- D_rB  out  4  registered rB.
- D_valC  out  DATA_WID  registered valC.
- D_valP  out  DATA_WID  registered valP.
- stat  out  2  0 = AOK, 1 = HLT, 2 = INS (invalid instruction).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - PC = RESET_PC, state RUN, stat 0.
  - D_valid 0; all other D_* outputs 0.
  - rst overrides every other input.
- Instruction length, with W = DATA_WID/8:
  - icode 0, 1, 9: 1 byte.
  - icode 2, 6, A, B: 2 bytes.
  - icode 3, 4, 5: 2+W bytes.
  - icode 7, 8: 1+W bytes.
- valP = PC + length, combinational, truncated to DATA_WID (wraps modulo 2^DATA_WID).
- Decisions are combinational on the current PC and memory fields; registers update at the edge. Latency from PC to D_* is 1 cycle.
- Priority per cycle: rst > redirect_valid > stall > normal fetch.
- RUN state, normal fetch:
  - D_* <= fields and valP; D_valid <= 1.
  - icode 7 (jXX, predict taken) or 8 (call): PC <= valC.
  - icode 9 (ret): PC holds; state <= WAIT_RET.
  - icode 0 (halt): PC holds; state <= HALT; stat <= 1.
  - icode > B: D_valid <= 0; PC holds; state <= ERR; stat <= 2.
  - All other icodes: PC <= valP.
- RUN + stall (no redirect): PC, D_*, state and stat all hold.
- redirect_valid, any state:
  - PC <= redirect_pc; D_valid <= 0 (squash the wrong-path instruction).
  - state <= RUN; stat <= 0.
  - This allows a speculatively fetched halt or invalid instruction to be cancelled.
- WAIT_RET: D_valid <= 0 every cycle, PC holds; stall has no effect; exits only on redirect_valid or rst.
- HALT / ERR: D_valid <= 0, PC holds, stat held; exits only on redirect_valid or rst.
- Stall during WAIT_RET, HALT or ERR: ignored.
- Reset mid-operation: a pending WAIT_RET or HALT is discarded and fetch restarts at RESET_PC the next cycle.
- D_* fields other than D_valid retain their old values when a bubble is inserted; consumers must qualify them with D_valid.

Test Plan:
- Reset, then irmovl: rst 1 for 2 cycles, then icode 3 at PC 0 (DATA_WID 32) -> PC 0 during reset; next cycle D_valid 1, D_icode 3, D_valP 6, PC 6.
- Jump prediction, then mispredict: jXX at PC 0x10 with valC 0x40 -> PC 0x40, D_valP 0x15. Then redirect_valid with redirect_pc 0x15 -> PC 0x15, D_valid 0, stat 0.
- ret handling: ret at PC 0x20 -> D_icode 9, state WAIT_RET, PC stays 0x20 and D_valid 0 for 3 cycles. Then redirect_pc 0x80 -> PC 0x80, fetch resumes.
- Stall vs redirect: stall 1 for 2 cycles at PC 0x8 -> PC and D_* unchanged. stall and redirect_valid together with redirect_pc 0x30 -> PC 0x30, D_valid 0.
- Halt, invalid and wrap-around:
  - halt at PC 0x4 -> stat 1, PC frozen; redirect_pc 0x100 -> stat 0, RUN.
  - icode 0xC -> stat 2, D_valid 0.
  - nop at PC 0xFFFFFFFF -> PC 0x00000000.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//
// Fetch-stage controller for the Y86 pipeline. Owns the PC register that
// addresses instruction memory, computes valP from the returned icode,
// predicts the next PC (jumps taken, calls to target), tracks fetch status
// and captures the fetched instruction into the F/D pipeline register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PC                  current fetch address to instruction memory
//   icode/ifun/rA/rB    decoded instruction fields from memory
//   valC                constant word from memory
//   stall               hold PC and F/D register (RUN state only)
//   redirect_valid/pc   downstream correction (mispredict or ret target)
//   D_valid             F/D register holds a real instruction (0 = bubble)
//   D_icode..D_valP     registered instruction fields and valP
//   stat                0 = AOK, 1 = HLT, 2 = INS
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter int                    DATA_WID = 32,
  parameter logic [DATA_WID-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [DATA_WID-1:0] PC,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [3:0]          rA,
  input  logic [3:0]          rB,
  input  logic [DATA_WID-1:0] valC,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [DATA_WID-1:0] redirect_pc,
  output logic                D_valid,
  output logic [3:0]          D_icode,
  output logic [3:0]          D_ifun,
  output logic [3:0]          D_rA,
  output logic [3:0]          D_rB,
  output logic [DATA_WID-1:0] D_valC,
  output logic [DATA_WID-1:0] D_valP,
  output logic [1:0]          stat
);

  localparam int W = DATA_WID / 8;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_RET = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  // Byte length of an instruction from its icode. Invalid icodes never
  // advance the PC, so their length is irrelevant.
  function automatic logic [DATA_WID-1:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = DATA_WID'(1);
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = DATA_WID'(2);
      4'h3, 4'h4, 4'h5:       instr_len = DATA_WID'(2 + W);
      4'h7, 4'h8:             instr_len = DATA_WID'(1 + W);
      default:                instr_len = DATA_WID'(1);
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic [1:0]          stat_q, stat_d;
  logic                d_valid_q, d_valid_d;
  logic [3:0]          d_icode_q, d_icode_d;
  logic [3:0]          d_ifun_q, d_ifun_d;
  logic [3:0]          d_ra_q, d_ra_d;
  logic [3:0]          d_rb_q, d_rb_d;
  logic [DATA_WID-1:0] d_valc_q, d_valc_d;
  logic [DATA_WID-1:0] d_valp_q, d_valp_d;
  logic [DATA_WID-1:0] valp;

  // valP wraps modulo 2^DATA_WID by construction of the adder width.
  assign valp = pc_q + instr_len(icode);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    d_valid_d = d_valid_q;
    d_icode_d = d_icode_q;
    d_ifun_d  = d_ifun_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_valc_d  = d_valc_q;
    d_valp_d  = d_valp_q;

    if (redirect_valid) begin
      // Squash the wrong-path instruction; also cancels a speculative
      // halt, invalid instruction or pending ret.
      pc_d      = redirect_pc;
      d_valid_d = 1'b0;
      state_d   = ST_RUN;
      stat_d    = STAT_AOK;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (icode > 4'hB) begin
              // Invalid instruction: bubble into decode, freeze fetch.
              d_valid_d = 1'b0;
              state_d   = ST_ERR;
              stat_d    = STAT_INS;
            end else begin
              d_valid_d = 1'b1;
              d_icode_d = icode;
              d_ifun_d  = ifun;
              d_ra_d    = rA;
              d_rb_d    = rB;
              d_valc_d  = valC;
              d_valp_d  = valp;
              case (icode)
                4'h7, 4'h8: pc_d = valC;  // jXX predicted taken; call target
                4'h9:       state_d = ST_WAIT_RET;
                4'h0: begin
                  state_d = ST_HALT;
                  stat_d  = STAT_HLT;
                end
                default:    pc_d = valp;
              endcase
            end
          end
        end
        // WAIT_RET, HALT and ERR all emit bubbles and ignore stall until a
        // redirect arrives.
        default: d_valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      d_valid_q <= 1'b0;
      d_icode_q <= '0;
      d_ifun_q  <= '0;
      d_ra_q    <= '0;
      d_rb_q    <= '0;
      d_valc_q  <= '0;
      d_valp_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      d_valid_q <= d_valid_d;
      d_icode_q <= d_icode_d;
      d_ifun_q  <= d_ifun_d;
      d_ra_q    <= d_ra_d;
      d_rb_q    <= d_rb_d;
      d_valc_q  <= d_valc_d;
      d_valp_q  <= d_valp_d;
    end
  end

  assign PC      = pc_q;
  assign stat    = stat_q;
  assign D_valid = d_valid_q;
  assign D_icode = d_icode_q;
  assign D_ifun  = d_ifun_q;
  assign D_rA    = d_ra_q;
  assign D_rB    = d_rb_q;
  assign D_valC  = d_valc_q;
  assign D_valP  = d_valp_q;

endmodule
